// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch redirect flush and memory
// freeze, with event counters and a sticky memory-wait timeout flag.
module pipe_hazard_ctrl #(
  parameter int CNT_W    = 16,
  parameter int MAX_WAIT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             wait_timeout
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    FLUSH    = 2'd2,
    MEM_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [15:0]      WAIT_MAX  = '1;
  localparam logic [15:0]      WAIT_LAST = 16'(MAX_WAIT - 1);

  state_t      state;
  logic [15:0] wait_cnt;
  logic        hazard;
  logic        freeze;
  logic        redirect;
  logic        ld_stall;

  // Classify the current cycle in priority order: freeze, redirect, load-use.
  always_comb begin
    hazard   = ex_mem_read && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && (id_rs1 == ex_rd)) ||
                (id_uses_rs2 && (id_rs2 == ex_rd)));
    freeze   = mem_busy;
    redirect = !mem_busy && ex_branch_taken;
    // A flushed ID slot holds a NOP, so its register fields are meaningless.
    ld_stall = !mem_busy && !ex_branch_taken && hazard && (state != FLUSH);
  end

  // Controls are held inactive throughout reset so the pipeline cannot advance.
  always_comb begin
    // NOTE: default every output first so no path through this block infers a latch.
    pc_write     = 1'b0;
    if_id_write  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    if (reset) begin
      if (freeze) begin
        pc_write    = 1'b0;
        if_id_write = 1'b0;
      end else if (redirect) begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
      end else if (ld_stall) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write    = 1'b1;
        if_id_write = 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      stall_count  <= '0;
      flush_count  <= '0;
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
    end else begin
      if (freeze)        state <= MEM_WAIT;
      else if (redirect) state <= FLUSH;
      else if (ld_stall) state <= STALL;
      else               state <= RUN;

      if ((freeze || ld_stall) && (stall_count != CNT_MAX))
        stall_count <= stall_count + CNT_W'(1);
      if (redirect && (flush_count != CNT_MAX))
        flush_count <= flush_count + CNT_W'(1);

      // Wait counter saturates so a very long freeze cannot wrap and re-trigger.
      if (mem_busy) begin
        if (wait_cnt != WAIT_MAX) wait_cnt <= wait_cnt + 16'd1;
        if (wait_cnt == WAIT_LAST) wait_timeout <= 1'b1;
      end else begin
        wait_cnt <= '0;
      end
    end
  end

  assign state_o = state;

endmodule
